// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchronizer plus tick-based debounce filter for
// the board slide switches and push buttons. It also produces one-cycle
// button rise pulses and sticky "pressed" flags that software clears.
module input_debouncer #(
    parameter int NUM_SW       = 16,
    parameter int NUM_BTN      = 16,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SW-1:0]  sw_raw,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] btn_clear,
    output logic [NUM_SW-1:0]  sw_clean,
    output logic [NUM_BTN-1:0] btn_clean,
    output logic [NUM_BTN-1:0] btn_rise,
    output logic [NUM_BTN-1:0] btn_sticky,
    output logic               tick
);

    // Switches occupy the low channel indices and buttons the high ones.
    // The filter logic is identical for both kinds of channel.
    localparam int NumCh = NUM_SW + NUM_BTN;
    localparam int CntW  = $clog2(STABLE_TICKS + 1);
    localparam int DivW  = $clog2(TICK_DIV);

    localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

    logic [NumCh-1:0]   rawAll;
    logic [NumCh-1:0]   syncFirst;
    logic [NumCh-1:0]   syncSecond;
    logic [NumCh-1:0]   cleanQ;
    logic [NumCh-1:0]   cleanNext;
    logic [CntW-1:0]    cntQ    [NumCh];
    logic [CntW-1:0]    cntNext [NumCh];
    logic [DivW-1:0]    divCount;
    logic               tickQ;
    logic [NUM_BTN-1:0] btnCleanNext;
    logic [NUM_BTN-1:0] btnCleanQ;
    logic [NUM_BTN-1:0] riseQ;
    logic [NUM_BTN-1:0] riseNext;
    logic [NUM_BTN-1:0] stickyQ;
    logic [NUM_BTN-1:0] stickyNext;

    assign rawAll = {btn_raw, sw_raw};

    // Two-flop synchronizer; the filter only ever looks at syncSecond.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncFirst  <= {NumCh{1'b0}};
            syncSecond <= {NumCh{1'b0}};
        end else begin
            syncFirst  <= rawAll;
            syncSecond <= syncFirst;
        end
    end

    // Prescaler: wraps every TICK_DIV cycles; tick is registered, so it is
    // high in the cycle right after the count reaches its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            divCount <= {DivW{1'b0}};
            tickQ    <= 1'b0;
        end else begin
            if (divCount == DivLast) begin
                divCount <= {DivW{1'b0}};
            end else begin
                divCount <= divCount + DivW'(1);
            end
            tickQ <= (divCount == DivLast);
        end
    end

    // Per-channel filter: any cycle of agreement clears progress, so only a
    // disagreement that survives STABLE_TICKS consecutive ticks flips clean.
    always_comb begin
        cleanNext = cleanQ;
        for (int i = 0; i < NumCh; i++) begin
            cntNext[i] = cntQ[i];
            if (syncSecond[i] == cleanQ[i]) begin
                cntNext[i] = {CntW{1'b0}};
            end else if (tickQ) begin
                if (cntQ[i] == CntLast) begin
                    cleanNext[i] = syncSecond[i];
                    cntNext[i]   = {CntW{1'b0}};
                end else begin
                    cntNext[i] = cntQ[i] + CntW'(1);
                end
            end else begin
                cntNext[i] = cntQ[i];
            end
        end
    end

    assign btnCleanNext = cleanNext[NUM_SW +: NUM_BTN];
    assign btnCleanQ    = cleanQ[NUM_SW +: NUM_BTN];

    // Rise pulse lines up with the first cycle clean reads 1. A clear that
    // arrives during the rise cycle is ignored so a fresh press never gets lost.
    always_comb begin
        riseNext   = btnCleanNext & ~btnCleanQ;
        stickyNext = riseNext | riseQ | (stickyQ & ~btn_clear);
    end

    // Filter state, clean levels and button event registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cleanQ  <= {NumCh{1'b0}};
            riseQ   <= {NUM_BTN{1'b0}};
            stickyQ <= {NUM_BTN{1'b0}};
            for (int i = 0; i < NumCh; i++) begin
                cntQ[i] <= {CntW{1'b0}};
            end
        end else begin
            cleanQ  <= cleanNext;
            riseQ   <= riseNext;
            stickyQ <= stickyNext;
            for (int i = 0; i < NumCh; i++) begin
                cntQ[i] <= cntNext[i];
            end
        end
    end

    assign sw_clean   = cleanQ[NUM_SW-1:0];
    assign btn_clean  = btnCleanQ;
    assign btn_rise   = riseQ;
    assign btn_sticky = stickyQ;
    assign tick       = tickQ;

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed scenarios plus randomized toggling, every cycle
// compared against a cycle-level reference model of the debounce rules.
module tb_input_debouncer;

    localparam int TD  = 4;
    localparam int ST  = 3;
    localparam int NCH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_raw;
    logic [15:0] btn_raw;
    logic [15:0] btn_clear;
    logic [15:0] sw_clean;
    logic [15:0] btn_clean;
    logic [15:0] btn_rise;
    logic [15:0] btn_sticky;
    logic        tick;

    int numChecks = 0;
    int numFails  = 0;

    // Reference model state
    logic [31:0] hist1   = 32'h0;
    logic [31:0] hist2   = 32'h0;
    logic [31:0] mClean  = 32'h0;
    int          mTicks [NCH];
    logic [15:0] mRise   = 16'h0;
    logic [15:0] mSticky = 16'h0;
    int          mCycle  = 0;

    input_debouncer #(
        .NUM_SW(16), .NUM_BTN(16), .TICK_DIV(TD), .STABLE_TICKS(ST)
    ) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw),
        .btn_clear(btn_clear), .sw_clean(sw_clean), .btn_clean(btn_clean),
        .btn_rise(btn_rise), .btn_sticky(btn_sticky), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs as driven.
    task automatic modelEdge();
        logic [31:0] s;
        logic [31:0] oldClean;
        logic [15:0] oldRise;
        bit          tickNow;
        if (rst) begin
            hist1 = 32'h0; hist2 = 32'h0; mClean = 32'h0;
            mRise = 16'h0; mSticky = 16'h0; mCycle = 0;
            for (int i = 0; i < NCH; i++) mTicks[i] = 0;
        end else begin
            s        = hist2;
            tickNow  = (mCycle != 0) && (mCycle % TD == 0);
            oldClean = mClean;
            for (int i = 0; i < NCH; i++) begin
                if (s[i] == mClean[i]) begin
                    mTicks[i] = 0;
                end else if (tickNow) begin
                    mTicks[i] = mTicks[i] + 1;
                    if (mTicks[i] == ST) begin
                        mClean[i] = s[i];
                        mTicks[i] = 0;
                    end
                end
            end
            oldRise = mRise;
            mRise   = mClean[31:16] & ~oldClean[31:16];
            // clear is ignored while the rise pulse is showing
            mSticky = mRise | (mSticky & ~(btn_clear & ~oldRise));
            hist2   = hist1;
            hist1   = {btn_raw, sw_raw};
            mCycle  = mCycle + 1;
        end
    endtask

    task automatic compareAll();
        checkEq("sw_clean",   {16'h0, sw_clean},   {16'h0, mClean[15:0]});
        checkEq("btn_clean",  {16'h0, btn_clean},  {16'h0, mClean[31:16]});
        checkEq("btn_rise",   {16'h0, btn_rise},   {16'h0, mRise});
        checkEq("btn_sticky", {16'h0, btn_sticky}, {16'h0, mSticky});
        checkEq("tick", {31'h0, tick}, {31'h0, (mCycle != 0) && (mCycle % TD == 0)});
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    initial begin
        int first;
        int second;
        int found;
        int rises;
        bit sawHigh;

        for (int i = 0; i < NCH; i++) mTicks[i] = 0;
        rst = 1'b1; sw_raw = 16'hFFFF; btn_raw = 16'h0; btn_clear = 16'h0;

        // 1. reset and tick phase
        repeat (3) step();
        checkEq("reset_sw_clean", {16'h0, sw_clean}, 32'h0);
        rst = 1'b0; sw_raw = 16'h0;
        first = 0; second = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) checkEq("post_reset_sticky", {16'h0, btn_sticky}, 32'h0);
            if (tick && first == 0) first = k;
            else if (tick && second == 0) second = k;
        end
        checkEq("tick_first", first, 32'd4);
        checkEq("tick_second", second, 32'd8);

        // 2. clean switch edge
        sw_raw = 16'hA5A5;
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (found == 0 && sw_clean == 16'hA5A5) found = k;
        end
        checkEq("sw_edge_window", {31'h0, found >= 11 && found <= 14}, 32'd1);
        sw_raw = 16'h0;
        repeat (20) step();
        checkEq("sw_back_low", {16'h0, sw_clean}, 32'h0);

        // 3. glitch rejection
        sawHigh = 1'b0;
        sw_raw[0] = 1'b1;
        repeat (6) begin step(); sawHigh |= sw_clean[0]; end
        sw_raw[0] = 1'b0;
        repeat (20) begin step(); sawHigh |= sw_clean[0]; end
        checkEq("glitch_pulse", {31'h0, sawHigh}, 32'd0);
        sawHigh = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sw_raw[0] = ((k / 3) % 2 == 0);
            step();
            sawHigh |= sw_clean[0];
        end
        sw_raw[0] = 1'b0;
        repeat (20) begin step(); sawHigh |= sw_clean[0]; end
        checkEq("glitch_chatter", {31'h0, sawHigh}, 32'd0);

        // 4. button rise and sticky
        btn_raw[3] = 1'b1;
        found = 0; rises = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            rises += int'(btn_rise[3]);
            if (found == 0 && btn_clean[3]) begin
                found = k;
                checkEq("btn3_rise_vec", {16'h0, btn_rise}, 32'h0008);
                checkEq("btn3_sticky_set", {31'h0, btn_sticky[3]}, 32'd1);
            end
        end
        checkEq("btn3_window", {31'h0, found >= 11 && found <= 14}, 32'd1);
        checkEq("btn3_rise_count", rises, 32'd1);
        btn_raw[3] = 1'b0;
        rises = 0;
        repeat (20) begin step(); rises += int'(btn_rise[3]); end
        checkEq("btn3_fall_clean", {31'h0, btn_clean[3]}, 32'd0);
        checkEq("btn3_fall_no_pulse", rises, 32'd0);
        checkEq("btn3_sticky_held", {31'h0, btn_sticky[3]}, 32'd1);
        btn_clear = 16'h0008;
        step();
        btn_clear = 16'h0;
        checkEq("btn3_cleared", {31'h0, btn_sticky[3]}, 32'd0);

        // 5. set/clear collision
        btn_raw[5] = 1'b1;
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            if (found == 0) begin
                step();
                if (btn_rise[5]) begin
                    found = 1;
                    btn_clear = 16'h0020;
                    step();
                    btn_clear = 16'h0;
                    checkEq("collision_sticky", {31'h0, btn_sticky[5]}, 32'd1);
                end
            end
        end
        checkEq("btn5_rise_seen", found, 32'd1);
        step();
        checkEq("collision_sticky_hold", {31'h0, btn_sticky[5]}, 32'd1);
        btn_raw[5] = 1'b0;
        repeat (20) step();

        // 6. reset mid-operation
        btn_raw[7] = 1'b1;
        rises = 0;
        repeat (8) begin step(); rises += int'(btn_rise[7]); end
        checkEq("btn7_no_early_rise", rises, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkEq("btn7_reset_sticky", {16'h0, btn_sticky}, 32'h0);
        found = 0; rises = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            rises += int'(btn_rise[7]);
            if (found == 0 && btn_clean[7]) found = k;
        end
        checkEq("btn7_window", {31'h0, found >= 11 && found <= 14}, 32'd1);
        checkEq("btn7_rise_count", rises, 32'd1);

        // 7. randomized toggling, clears and occasional reset
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) sw_raw[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) btn_raw[$urandom_range(0, 15)] ^= 1'b1;
            btn_clear = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h0;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
